// File: rtl/controlador_es_if.sv
// Handshake and board I/O bundle between the control unit and controlador_es.
// slave = controller side, master = control unit / board side.
interface controlador_es_if #(
  parameter int LARGURA_DADO   = 32,
  parameter int LARGURA_CHAVES = 16
);
  logic                      in_req;
  logic                      out_req;
  logic                      botao;
  logic [LARGURA_CHAVES-1:0] chaves;
  logic [LARGURA_DADO-1:0]   dado_saida;
  logic                      sinal;
  logic [LARGURA_DADO-1:0]   dado_entrada;
  logic [LARGURA_DADO-1:0]   display_reg;
  logic                      aguardando;

  modport slave (
    input  in_req, out_req, botao, chaves, dado_saida,
    output sinal, dado_entrada, display_reg, aguardando
  );

  modport master (
    output in_req, out_req, botao, chaves, dado_saida,
    input  sinal, dado_entrada, display_reg, aguardando
  );
endinterface

// File: rtl/controlador_es.sv
// I/O handshake controller: debounced button confirms in/out transfers.
// CONTROLADOR_ES_DEBOUNCE_BYPASS_EN: use synchronized button directly.
module controlador_es #(
  parameter int LARGURA_DADO    = 32,
  parameter int LARGURA_CHAVES  = 16,
  parameter int DEBOUNCE_CICLOS = 500000
) (
  input  logic             clock,
  input  logic             reset,
  controlador_es_if.slave  bus
);

  typedef enum logic [1:0] {
    OCIOSO,
    ESPERA_PRESS,
    ESPERA_SOLTA,
    CONCLUI
  } estado_e;

  typedef enum logic {
    OP_IN,
    OP_OUT
  } op_e;

  logic sync1_q, sync2_q;
  logic deb_q, deb_d;
  logic deb_prev_q;
  logic press, solta;

  estado_e estado_q, estado_d;
  op_e     op_q, op_d;
  logic    req_ativo;

  logic                    sinal_q, sinal_d;
  logic                    aguard_q, aguard_d;
  logic [LARGURA_DADO-1:0] din_q, din_d;
  logic [LARGURA_DADO-1:0] disp_q, disp_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
    end else begin
      sync1_q    <= bus.botao;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
    end
  end

`ifdef CONTROLADOR_ES_DEBOUNCE_BYPASS_EN
  always_comb deb_d = sync2_q;
`else
  localparam int CNT_W = $clog2(DEBOUNCE_CICLOS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(DEBOUNCE_CICLOS - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Level flips on the Nth consecutive mismatch; never exceeds CNT_MAX
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (sync2_q != deb_q) begin
      if (cnt_q >= CNT_MAX) begin
        deb_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`endif

  assign press = deb_q & ~deb_prev_q;
  assign solta = ~deb_q & deb_prev_q;

  assign req_ativo = (op_q == OP_IN) ? bus.in_req
                                     : bus.out_req;

  always_comb begin
    estado_d = estado_q;
    op_d     = op_q;
    din_d    = din_q;
    disp_d   = disp_q;
    unique case (estado_q)
      OCIOSO: begin
        if (bus.in_req) begin
          op_d     = OP_IN;
          estado_d = ESPERA_PRESS;
        end else if (bus.out_req) begin
          op_d     = OP_OUT;
          estado_d = ESPERA_PRESS;
        end
      end
      ESPERA_PRESS: begin
        if (!req_ativo) begin
          estado_d = OCIOSO;
        end else if (press) begin
          if (op_q == OP_IN)
            din_d = LARGURA_DADO'(bus.chaves);
          else
            disp_d = bus.dado_saida;
          estado_d = ESPERA_SOLTA;
        end
      end
      ESPERA_SOLTA: begin
        if (solta)           estado_d = CONCLUI;
        else if (!req_ativo) estado_d = OCIOSO;
      end
      CONCLUI: estado_d = OCIOSO;
      default: estado_d = OCIOSO;
    endcase
    sinal_d  = (estado_d == CONCLUI);
    aguard_d = (estado_d == ESPERA_PRESS) ||
               (estado_d == ESPERA_SOLTA);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q <= OCIOSO;
      op_q     <= OP_IN;
      sinal_q  <= 1'b0;
      aguard_q <= 1'b0;
      din_q    <= '0;
      disp_q   <= '0;
    end else begin
      estado_q <= estado_d;
      op_q     <= op_d;
      sinal_q  <= sinal_d;
      aguard_q <= aguard_d;
      din_q    <= din_d;
      disp_q   <= disp_d;
    end
  end

  assign bus.sinal        = sinal_q;
  assign bus.aguardando   = aguard_q;
  assign bus.dado_entrada = din_q;
  assign bus.display_reg  = disp_q;

endmodule

// File: tb/tb_controlador_es.sv
// Directed bench for controlador_es with DEBOUNCE_CICLOS=4.
// Press/release to sinal latency: 7 cycles after the button is driven.
module tb_controlador_es;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   pulses   = 0;

  controlador_es_if #(
    .LARGURA_DADO  (32),
    .LARGURA_CHAVES(16)
  ) bus ();

  controlador_es #(
    .LARGURA_DADO   (32),
    .LARGURA_CHAVES (16),
    .DEBOUNCE_CICLOS(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clock = ~clock;

  always @(posedge clock)
    if (bus.sinal === 1'b1) pulses++;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic press_release(output int lat);
    bus.botao = 1'b1;
    repeat (10) tick();
    bus.botao = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (bus.sinal === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) tick();
    n_checks++;
    if (bus.sinal !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_sinal: got %b want 0", bus.sinal);
    end
    n_checks++;
    if (bus.aguardando !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_aguard: got %b want 0", bus.aguardando);
    end
    n_checks++;
    if (bus.dado_entrada !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_din: got %h want 0", bus.dado_entrada);
    end
    n_checks++;
    if (bus.display_reg !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_disp: got %h want 0", bus.display_reg);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_in();
    int p0 = pulses;
    int lat;
    bus.in_req = 1'b1;
    bus.chaves = 16'hA5C3;
    tick();
    n_checks++;
    if (bus.aguardando !== 1'b1) begin
      n_fail++;
      $display("FAIL in_aguard: got %b want 1", bus.aguardando);
    end
    bus.botao = 1'b1;
    repeat (6) tick();
    n_checks++;
    if (bus.dado_entrada !== 32'h0) begin
      n_fail++;
      $display("FAIL in_early: got %h want 0", bus.dado_entrada);
    end
    tick();
    n_checks++;
    if (bus.dado_entrada !== 32'h0000A5C3) begin
      n_fail++;
      $display("FAIL in_latch: got %h want 0000a5c3",
               bus.dado_entrada);
    end
    repeat (3) tick();
    bus.botao = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (bus.aguardando !== 1'b1 && bus.sinal !== 1'b1) begin
        n_checks++;
        n_fail++;
        $display("FAIL in_aguard_hold: dropped at %0d", i);
        break;
      end
      if (bus.sinal === 1'b1) begin
        lat = i;
        break;
      end
    end
    n_checks++;
    if (lat !== 7) begin
      n_fail++;
      $display("FAIL in_latency: got %0d want 7", lat);
    end
    n_checks++;
    if (bus.aguardando !== 1'b0) begin
      n_fail++;
      $display("FAIL in_aguard_conclui: got %b want 0",
               bus.aguardando);
    end
    bus.in_req = 1'b0;
    tick();
    n_checks++;
    if (bus.sinal !== 1'b0) begin
      n_fail++;
      $display("FAIL in_pulse_width: got %b want 0", bus.sinal);
    end
    repeat (3) tick();
    n_checks++;
    if (pulses - p0 !== 1) begin
      n_fail++;
      $display("FAIL in_pulses: got %0d want 1", pulses - p0);
    end
  endtask

  task automatic test_out();
    int p0 = pulses;
    int lat;
    bus.out_req    = 1'b1;
    bus.dado_saida = 32'hDEADBEEF;
    bus.chaves     = 16'h1234;
    tick();
    press_release(lat);
    bus.out_req = 1'b0;
    n_checks++;
    if (lat !== 7) begin
      n_fail++;
      $display("FAIL out_latency: got %0d want 7", lat);
    end
    tick();
    repeat (3) tick();
    n_checks++;
    if (bus.display_reg !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL out_disp: got %h want deadbeef",
               bus.display_reg);
    end
    n_checks++;
    if (bus.dado_entrada !== 32'h0000A5C3) begin
      n_fail++;
      $display("FAIL out_din_kept: got %h want 0000a5c3",
               bus.dado_entrada);
    end
    n_checks++;
    if (pulses - p0 !== 1) begin
      n_fail++;
      $display("FAIL out_pulses: got %0d want 1", pulses - p0);
    end
  endtask

  task automatic test_glitch();
    int p0 = pulses;
    int lat;
    bus.in_req = 1'b1;
    bus.chaves = 16'hFFFF;
    tick();
    bus.botao = 1'b1;
    repeat (3) tick();
    bus.botao = 1'b0;
    repeat (10) tick();
    n_checks++;
    if (bus.dado_entrada !== 32'h0000A5C3) begin
      n_fail++;
      $display("FAIL glitch_din: got %h want 0000a5c3",
               bus.dado_entrada);
    end
    n_checks++;
    if (bus.aguardando !== 1'b1) begin
      n_fail++;
      $display("FAIL glitch_aguard: got %b want 1",
               bus.aguardando);
    end
    n_checks++;
    if (pulses - p0 !== 0) begin
      n_fail++;
      $display("FAIL glitch_pulses: got %0d want 0", pulses - p0);
    end
    press_release(lat);
    bus.in_req = 1'b0;
    n_checks++;
    if (lat !== 7 || bus.dado_entrada !== 32'h0000FFFF) begin
      n_fail++;
      $display("FAIL glitch_after: lat %0d din %h want 7 0000ffff",
               lat, bus.dado_entrada);
    end
    repeat (2) tick();
  endtask

  task automatic test_held();
    int p0 = pulses;
    int lat;
    bus.botao = 1'b1;
    repeat (10) tick();
    bus.in_req = 1'b1;
    bus.chaves = 16'h1111;
    repeat (10) tick();
    n_checks++;
    if (bus.dado_entrada !== 32'h0000FFFF ||
        bus.aguardando !== 1'b1) begin
      n_fail++;
      $display("FAIL held_press: din %h aguard %b want 0000ffff 1",
               bus.dado_entrada, bus.aguardando);
    end
    bus.botao = 1'b0;
    repeat (10) tick();
    n_checks++;
    if (pulses - p0 !== 0 || bus.dado_entrada !== 32'h0000FFFF) begin
      n_fail++;
      $display("FAIL held_release: pulses %0d din %h want 0 0000ffff",
               pulses - p0, bus.dado_entrada);
    end
    bus.chaves = 16'h2222;
    press_release(lat);
    bus.in_req = 1'b0;
    n_checks++;
    if (lat !== 7 || bus.dado_entrada !== 32'h00002222) begin
      n_fail++;
      $display("FAIL held_confirm: lat %0d din %h want 7 00002222",
               lat, bus.dado_entrada);
    end
    repeat (2) tick();
  endtask

  task automatic test_abort();
    int p0 = pulses;
    bus.out_req    = 1'b1;
    bus.dado_saida = 32'hCAFEF00D;
    tick();
    n_checks++;
    if (bus.aguardando !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_enter: got %b want 1", bus.aguardando);
    end
    bus.out_req = 1'b0;
    tick();
    n_checks++;
    if (bus.aguardando !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_idle: got %b want 0", bus.aguardando);
    end
    bus.botao = 1'b1;
    repeat (10) tick();
    bus.botao = 1'b0;
    repeat (10) tick();
    n_checks++;
    if (bus.display_reg !== 32'hDEADBEEF || pulses - p0 !== 0) begin
      n_fail++;
      $display("FAIL abort_kept: disp %h pulses %0d want deadbeef 0",
               bus.display_reg, pulses - p0);
    end
  endtask

  task automatic test_reset_mid();
    int p0;
    bus.in_req = 1'b1;
    bus.chaves = 16'h3333;
    tick();
    bus.botao = 1'b1;
    repeat (10) tick();
    n_checks++;
    if (bus.dado_entrada !== 32'h00003333 ||
        bus.aguardando !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_latch: din %h aguard %b want 00003333 1",
               bus.dado_entrada, bus.aguardando);
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (bus.dado_entrada !== 32'h0 || bus.display_reg !== 32'h0 ||
        bus.aguardando !== 1'b0 || bus.sinal !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_async: din %h disp %h ag %b s %b want 0",
               bus.dado_entrada, bus.display_reg,
               bus.aguardando, bus.sinal);
    end
    bus.in_req = 1'b0;
    bus.botao  = 1'b0;
    repeat (2) tick();
    p0 = pulses;
    reset = 1'b0;
    repeat (15) tick();
    n_checks++;
    if (pulses - p0 !== 0 || bus.aguardando !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_after: pulses %0d aguard %b want 0 0",
               pulses - p0, bus.aguardando);
    end
  endtask

  task automatic test_back_to_back();
    int p0 = pulses;
    int lat;
    bus.in_req     = 1'b1;
    bus.out_req    = 1'b1;
    bus.chaves     = 16'h4444;
    bus.dado_saida = 32'h55555555;
    tick();
    press_release(lat);
    bus.out_req = 1'b0;
    n_checks++;
    if (lat !== 7 || bus.dado_entrada !== 32'h00004444 ||
        bus.display_reg !== 32'h0) begin
      n_fail++;
      $display("FAIL prio: lat %0d din %h disp %h want 7 4444 0",
               lat, bus.dado_entrada, bus.display_reg);
    end
    tick();
    n_checks++;
    if (bus.sinal !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_gap: got %b want 0", bus.sinal);
    end
    tick();
    n_checks++;
    if (bus.aguardando !== 1'b1 || bus.sinal !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_rearm: aguard %b sinal %b want 1 0",
               bus.aguardando, bus.sinal);
    end
    bus.chaves = 16'h6666;
    press_release(lat);
    bus.in_req = 1'b0;
    n_checks++;
    if (lat !== 7 || bus.dado_entrada !== 32'h00006666) begin
      n_fail++;
      $display("FAIL b2b_second: lat %0d din %h want 7 00006666",
               lat, bus.dado_entrada);
    end
    repeat (3) tick();
    n_checks++;
    if (pulses - p0 !== 2) begin
      n_fail++;
      $display("FAIL b2b_pulses: got %0d want 2", pulses - p0);
    end
  endtask

  initial begin
    bus.in_req     = 1'b0;
    bus.out_req    = 1'b0;
    bus.botao      = 1'b0;
    bus.chaves     = '0;
    bus.dado_saida = '0;
    test_reset();
    test_in();
    test_out();
    test_glitch();
    test_held();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/controlador_es.md
Name: controlador_es

Overview:
- I/O handshake controller that sits beside the control unit.
- Consumes the control unit's `in`/`out`/`stop` request strobes. Produces the `sinal` acknowledge that releases the stalled processor.
- Latches switch data for `in` instructions and register data for `out` instructions, both gated by a debounced pushbutton confirmation.
- Output side drives the board's display register.

Parameters:
- LARGURA_DADO, 32, width of datapath words (`dado_saida`, `dado_entrada`, `display_reg`).
- LARGURA_CHAVES, 16, number of input switches; must be ≤ LARGURA_DADO.
- DEBOUNCE_CICLOS, 500000, consecutive stable cycles required to accept a button level change (10 ms at 50 MHz).

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_req  input  1  `in` strobe from the control unit (an `in` instruction is stalled).
- out_req  input  1  `out` strobe from the control unit (an `out` instruction is stalled).
- botao  input  1  raw, asynchronous pushbutton, active-high.
- chaves  input  LARGURA_CHAVES  raw switch levels.
- dado_saida  input  LARGURA_DADO  register-file value to display on `out`.
- sinal  output  1  acknowledge to the control unit; one-cycle pulse.
- dado_entrada  output  LARGURA_DADO  captured switch value, zero-extended.
- display_reg  output  LARGURA_DADO  last value shown by an `out`.
- aguardando  output  1  high while waiting for the operator (drives an LED).

Behaviour:
- Reset values (asynchronous, while reset=1): `sinal`=0, `dado_entrada`=0, `display_reg`=0, `aguardando`=0, FSM=OCIOSO, debounce counter=0, debounced button=0, synchronizer flops=0.
- Button path:
  - `botao` passes through a 2-flop synchronizer.
  - The debounced level changes only after the synchronized level has differed from it for DEBOUNCE_CICLOS consecutive cycles. Any mismatch-free cycle clears the counter.
  - Counter width is the minimum holding DEBOUNCE_CICLOS, and it saturates rather than wraps.
  - Press event = debounced 0→1. Release event = debounced 1→0.
- FSM states: OCIOSO, ESPERA_PRESS, ESPERA_SOLTA, CONCLUI.
- OCIOSO:
  - `sinal`=0, `aguardando`=0.
  - If `in_req`, record op=IN and go to ESPERA_PRESS.
  - Else if `out_req`, record op=OUT and go to ESPERA_PRESS.
  - If both are asserted, IN wins.
- ESPERA_PRESS:
  - `aguardando`=1.
  - If the recorded request drops, go to OCIOSO with no latch (abort).
  - If the debounced button is already 1 on entry, wait for a release first; a held button never confirms.
  - On a press event:
    - op=IN: `dado_entrada` <= zero-extended `chaves` sampled that cycle.
    - op=OUT: `display_reg` <= `dado_saida` sampled that cycle.
    - Go to ESPERA_SOLTA.
- ESPERA_SOLTA:
  - `aguardando`=1.
  - On a release event, go to CONCLUI.
  - A request drop here goes to OCIOSO; already-latched data is kept.
- CONCLUI:
  - `sinal`=1 for exactly this one cycle, `aguardando`=0.
  - Unconditionally go to OCIOSO.
- Latency and gaps:
  - Release event to `sinal` high = 1 cycle (registered output).
  - `sinal` is low for at least one cycle between transactions, so back-to-back `in`/`out` instructions each need their own press/release.
- Stability: `dado_entrada` and `display_reg` hold their values between transactions and change only at the press event.
- Reset mid-transaction: immediate return to reset values; no pending `sinal`.

Optional Feature:
- Macro: CONTROLADOR_ES_DEBOUNCE_BYPASS_EN.
- Defined: the debounce counter is removed. The synchronized button is the debounced level, so press/release events occur one cycle after the synchronizer output changes (simulation speed-up).
- Undefined: full DEBOUNCE_CICLOS filtering as above.

Test Plan:
- Tests run with DEBOUNCE_CICLOS=4 and the bypass macro undefined.
- IN transaction: reset, `in_req`=1, `chaves`=16'hA5C3, press 10 cycles, release 10 cycles → `dado_entrada`=32'h0000A5C3; exactly one `sinal` pulse 1 cycle after the debounced release; `aguardando` high from the cycle after `in_req` until CONCLUI.
- OUT transaction: `out_req`=1, `dado_saida`=32'hDEADBEEF, press/release → `display_reg`=32'hDEADBEEF, one `sinal` pulse; `dado_entrada` unchanged.
- Glitch rejection: while in ESPERA_PRESS, `botao` high for 3 cycles then low → no latch, no `sinal`; FSM stays in ESPERA_PRESS.
- Held button: `botao` already high and stable before `in_req` → no `sinal` until release, press, release; the latched value is `chaves` at the second press.
- Abort and reset: `out_req` dropped in ESPERA_PRESS → OCIOSO, `display_reg` unchanged, no `sinal`. Separately, reset asserted in ESPERA_SOLTA → all outputs 0 on the same edge; no `sinal` after deassertion.
- Priority and back-to-back: `in_req` and `out_req` both 1 → IN path taken. After a `sinal` pulse with `in_req` held, the next pulse requires a new press/release, and `sinal` is low for at least 1 cycle between pulses.
